// File: rtl/miner_ctrl_pkg.sv
// Shared state encodings for the multi-core miner controller.
package miner_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_MID   = 3'd1,
    ST_HDR   = 3'd2,
    ST_SOLVE = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam int STATE_W = 3;
  localparam int IDX_W   = 4;

endpackage

// File: rtl/miner_claim_arbiter.sv
// Lowest-index priority encoder over per-core solution claims.
module miner_claim_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic [NUM_CORES-1:0] i_req,
  output logic [3:0]           o_id,
  output logic                 o_any
);

  always_comb begin
    o_id  = 4'd0;
    o_any = |i_req;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (i_req[i]) o_id = 4'(i);
    end
  end

endmodule

// File: rtl/miner_ctrl_multi.sv
// Job load / solve / halt controller for NUM_CORES solver cores.
// Define MINER_CTRL_HALT_TIMEOUT_EN to auto-resume from HALT after HALT_TIMEOUT cycles.
module miner_ctrl_multi
  import miner_ctrl_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int MID_WORDS = 8,
  parameter int HDR_WORDS = 3
`ifdef MINER_CTRL_HALT_TIMEOUT_EN
  ,
  parameter int HALT_TIMEOUT = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start_found,
  input  logic                 word_valid,
  input  logic [NUM_CORES-1:0] sol_claim,
  input  logic                 sol_response,
  input  logic                 sol_reject,
  output logic [2:0]           state,
  output logic                 idle_st,
  output logic                 mid_st,
  output logic                 head_st,
  output logic                 solve_st,
  output logic                 halt_st,
  output logic [NUM_CORES-1:0] core_en,
  output logic [3:0]           word_idx,
  output logic [3:0]           winner_id,
  output logic                 claim_valid
);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [3:0]           r_word_idx;
  logic [3:0]           w_idx_next;
  logic [3:0]           r_winner;
  logic [NUM_CORES-1:0] r_core_en;
  logic [3:0]           w_arb_id;
  logic                 w_arb_any;
  logic                 w_resume;
  logic                 w_mid_last;
  logic                 w_hdr_last;

  miner_claim_arbiter #(
    .NUM_CORES (NUM_CORES)
  ) u_arb (
    .i_req (sol_claim),
    .o_id  (w_arb_id),
    .o_any (w_arb_any)
  );

  assign w_mid_last = (r_word_idx == 4'(MID_WORDS - 1));
  assign w_hdr_last = (r_word_idx == 4'(HDR_WORDS - 1));

`ifdef MINER_CTRL_HALT_TIMEOUT_EN
  localparam int TW = $clog2(HALT_TIMEOUT) + 1;
  logic [TW-1:0] r_halt_cnt;

  // Counts cycles spent in HALT; value k means k edges since entry.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_halt_cnt <= '0;
    end else if (w_next == ST_HALT && r_state == ST_HALT) begin
      r_halt_cnt <= r_halt_cnt + 1'b1;
    end else begin
      r_halt_cnt <= '0;
    end
  end

  assign w_resume = sol_reject ||
                    (r_halt_cnt == TW'(HALT_TIMEOUT - 1));
`else
  assign w_resume = sol_reject;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= ST_IDLE;
      r_word_idx <= 4'd0;
      r_core_en  <= '0;
    end else begin
      r_state    <= w_next;
      r_word_idx <= w_idx_next;
      r_core_en  <= {NUM_CORES{w_next == ST_SOLVE}};
    end
  end

  always_comb begin
    w_next = ST_IDLE;
    if (start_found) begin
      w_next = ST_MID;
    end else if (sol_response) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  w_next = ST_IDLE;
        ST_MID:   w_next = (word_valid && w_mid_last) ? ST_HDR : ST_MID;
        ST_HDR:   w_next = (word_valid && w_hdr_last) ? ST_SOLVE : ST_HDR;
        ST_SOLVE: w_next = w_arb_any ? ST_HALT : ST_SOLVE;
        ST_HALT:  w_next = w_resume ? ST_SOLVE : ST_HALT;
        default:  w_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_idx_next = r_word_idx;
    if (start_found || sol_response) begin
      w_idx_next = 4'd0;
    end else if (r_state == ST_MID && word_valid) begin
      w_idx_next = w_mid_last ? 4'd0 : r_word_idx + 4'd1;
    end else if (r_state == ST_HDR && word_valid) begin
      w_idx_next = w_hdr_last ? 4'd0 : r_word_idx + 4'd1;
    end
  end

  // Winner only latches on a genuine SOLVE->HALT transition.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_winner <= 4'd0;
    end else if (r_state == ST_SOLVE && w_next == ST_HALT) begin
      r_winner <= w_arb_id;
    end
  end

  always_comb begin
    state       = r_state;
    idle_st     = (r_state == ST_IDLE);
    mid_st      = (r_state == ST_MID);
    head_st     = (r_state == ST_HDR);
    solve_st    = (r_state == ST_SOLVE);
    halt_st     = (r_state == ST_HALT);
    claim_valid = (r_state == ST_HALT);
    core_en     = r_core_en;
    word_idx    = r_word_idx;
    winner_id   = r_winner;
  end

endmodule

// File: tb/tb_miner_ctrl_multi.sv
// Directed bench for miner_ctrl_multi.
module tb_miner_ctrl_multi;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start_found;
  logic       word_valid;
  logic [3:0] sol_claim;
  logic       sol_response;
  logic       sol_reject;
  logic [2:0] state;
  logic       idle_st, mid_st, head_st, solve_st, halt_st;
  logic [3:0] core_en;
  logic [3:0] word_idx;
  logic [3:0] winner_id;
  logic       claim_valid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

`ifdef MINER_CTRL_HALT_TIMEOUT_EN
  miner_ctrl_multi #(.NUM_CORES(4), .MID_WORDS(8), .HDR_WORDS(3),
                     .HALT_TIMEOUT(16)) dut (
`else
  miner_ctrl_multi #(.NUM_CORES(4), .MID_WORDS(8), .HDR_WORDS(3)) dut (
`endif
    .clk          (clk),
    .n_rst        (n_rst),
    .start_found  (start_found),
    .word_valid   (word_valid),
    .sol_claim    (sol_claim),
    .sol_response (sol_response),
    .sol_reject   (sol_reject),
    .state        (state),
    .idle_st      (idle_st),
    .mid_st       (mid_st),
    .head_st      (head_st),
    .solve_st     (solve_st),
    .halt_st      (halt_st),
    .core_en      (core_en),
    .word_idx     (word_idx),
    .winner_id    (winner_id),
    .claim_valid  (claim_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic words(input int n);
    word_valid = 1'b1;
    repeat (n) tick();
    word_valid = 1'b0;
  endtask

  task automatic start_job();
    start_found = 1'b1;
    tick();
    start_found = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0;
    start_found = 1'b0;
    word_valid = 1'b0;
    sol_claim = 4'h0;
    sol_response = 1'b0;
    sol_reject = 1'b0;
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_idle", 32'(idle_st), 1);
    chk("rst_core_en", 32'(core_en), 0);
    chk("rst_idx", 32'(word_idx), 0);
    chk("rst_winner", 32'(winner_id), 0);
    chk("rst_claim", 32'(claim_valid), 0);
    n_rst = 1'b1;
    tick();

    word_valid = 1'b1;
    tick();
    word_valid = 1'b0;
    chk("idle_ignore_word", 32'(word_idx), 0);

    start_job();
    chk("start_mid", 32'(state), 1);
    chk("start_mid_st", 32'(mid_st), 1);
    words(5);
    chk("mid_idx5", 32'(word_idx), 5);
    words(3);
    chk("mid_to_hdr", 32'(state), 2);
    chk("hdr_idx0", 32'(word_idx), 0);
    chk("hdr_core_off", 32'(core_en), 0);
    words(3);
    chk("hdr_to_solve", 32'(state), 3);
    chk("solve_core_en", 32'(core_en), 32'hF);
    chk("solve_st", 32'(solve_st), 1);

    sol_claim = 4'b1010;
    tick();
    sol_claim = 4'h0;
    chk("halt_state", 32'(state), 4);
    chk("halt_winner", 32'(winner_id), 1);
    chk("halt_claim", 32'(claim_valid), 1);
    chk("halt_core_off", 32'(core_en), 0);

    sol_claim = 4'b0001;
    sol_reject = 1'b1;
    tick();
    sol_reject = 1'b0;
    sol_claim = 4'h0;
    chk("reject_solve", 32'(state), 3);
    chk("reject_winner", 32'(winner_id), 1);
    chk("reject_core_en", 32'(core_en), 32'hF);

    sol_claim = 4'b1100;
    tick();
    sol_claim = 4'h0;
    chk("halt2_winner", 32'(winner_id), 2);

    sol_response = 1'b1;
    sol_reject = 1'b1;
    tick();
    sol_response = 1'b0;
    sol_reject = 1'b0;
    chk("resp_wins_idle", 32'(state), 0);
    chk("resp_claim_off", 32'(claim_valid), 0);
    sol_claim = 4'hF;
    tick();
    sol_claim = 4'h0;
    chk("idle_claim_state", 32'(state), 0);
    chk("idle_claim_winner", 32'(winner_id), 2);

    start_job();
    words(8);
    words(2);
    chk("hdr_idx2", 32'(word_idx), 2);
    start_found = 1'b1;
    word_valid = 1'b1;
    tick();
    start_found = 1'b0;
    word_valid = 1'b0;
    chk("restart_mid", 32'(state), 1);
    chk("restart_idx", 32'(word_idx), 0);

    words(5);
    chk("pre_rst_idx", 32'(word_idx), 5);
    #2;
    n_rst = 1'b0;
    #2;
    chk("async_rst_state", 32'(state), 0);
    chk("async_rst_idx", 32'(word_idx), 0);
    n_rst = 1'b1;
    tick();
    start_job();
    words(8);
    chk("after_rst_hdr", 32'(state), 2);

    words(3);
    sol_response = 1'b1;
    tick();
    sol_response = 1'b0;
    chk("solve_resp_idle", 32'(state), 0);

    start_job();
    words(11);
    sol_claim = 4'b0001;
    tick();
    sol_claim = 4'h0;
    chk("halt3_winner", 32'(winner_id), 0);
    start_found = 1'b1;
    sol_response = 1'b1;
    tick();
    start_found = 1'b0;
    sol_response = 1'b0;
    chk("start_over_resp", 32'(state), 1);

    start_job();
    words(11);
    sol_claim = 4'b0100;
    tick();
    sol_claim = 4'h0;
    chk("halt4_state", 32'(state), 4);
`ifdef MINER_CTRL_HALT_TIMEOUT_EN
    repeat (15) tick();
    chk("timeout_hold15", 32'(state), 4);
    tick();
    chk("timeout_solve16", 32'(state), 3);
    chk("timeout_winner", 32'(winner_id), 2);
`else
    repeat (2000) tick();
    chk("no_timeout_halt", 32'(state), 4);
    chk("no_timeout_winner", 32'(winner_id), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
